// File: rtl/pong_physics.sv
`default_nettype none
// ============================================================================
// Module      : pong_physics
// Description : Per-frame pong game-state engine (paddles, ball, scoring).
// Revision    : 1.0 - initial release
// ============================================================================
module pong_physics #(
  parameter int CURSOR_WIDTH  = 20,
  parameter int CURSOR_OFFSET = 20,
  parameter int CURSOR_HEIGHT = 160,
  parameter int BALL_SIDE     = 30,
  parameter int FRAME_WIDTH   = 1280,
  parameter int FRAME_HEIGHT  = 960,
  parameter int BALL_SPEED    = 4,
  parameter int CURSOR_SPEED  = 6,
  parameter int SERVE_FRAMES  = 60,
  parameter int WIN_SCORE     = 9
) (
  input  logic        pxClk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        left_up,
  input  logic        left_down,
  input  logic        right_up,
  input  logic        right_down,
  input  logic        start,
  output logic [11:0] cursor_left_py,
  output logic [11:0] cursor_right_py,
  output logic [11:0] ball_px,
  output logic [11:0] ball_py,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic [1:0]  game_state
);

  localparam int c_cnt_w = $clog2(SERVE_FRAMES + 1);

  localparam logic [11:0] c_cur_min   = 12'(CURSOR_HEIGHT / 2);
  localparam logic [11:0] c_cur_max   = 12'(FRAME_HEIGHT - CURSOR_HEIGHT / 2);
  localparam logic [11:0] c_cur_spd   = 12'(CURSOR_SPEED);
  localparam logic [11:0] c_ball_spd  = 12'(BALL_SPEED);
  localparam logic [11:0] c_center_x  = 12'(FRAME_WIDTH / 2);
  localparam logic [11:0] c_center_y  = 12'(FRAME_HEIGHT / 2);
  localparam logic [11:0] c_y_min     = 12'(BALL_SIDE / 2);
  localparam logic [11:0] c_y_max     = 12'(FRAME_HEIGHT - BALL_SIDE / 2);
  localparam logic [11:0] c_r_face    = 12'(FRAME_WIDTH - CURSOR_OFFSET - CURSOR_WIDTH - BALL_SIDE / 2);
  localparam logic [11:0] c_l_face    = 12'(CURSOR_OFFSET + CURSOR_WIDTH + BALL_SIDE / 2);
  localparam logic [11:0] c_r_miss    = 12'(FRAME_WIDTH - BALL_SIDE / 2);
  localparam logic [11:0] c_l_miss    = 12'(BALL_SIDE / 2 + BALL_SPEED);
  localparam logic [11:0] c_hit_win   = 12'((CURSOR_HEIGHT + BALL_SIDE) / 2);
  localparam logic [3:0]  c_win       = 4'(WIN_SCORE);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_prev;
  logic                 r_tick;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [11:0]          r_cur_l, r_cur_r, r_px, r_py;
  logic                 r_dx, r_dy;
  logic [3:0]           r_score_l, r_score_r;

  logic [11:0] w_nx, w_px_n, w_py_n;
  logic        w_dx_n, w_dy_n, w_hit_l, w_hit_r, w_miss_l, w_miss_r;

  function automatic logic [11:0] paddle_next(input logic [11:0] py, input logic up, input logic dn);
    logic [11:0] nxt;
    nxt = py;
    // Clamp is tested before the subtract so py never wraps below zero.
    if (up && !dn)
      nxt = (py < c_cur_min + c_cur_spd) ? c_cur_min : py - c_cur_spd;
    else if (dn && !up)
      nxt = (py + c_cur_spd > c_cur_max) ? c_cur_max : py + c_cur_spd;
    return nxt;
  endfunction

  function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  assign w_nx    = r_px + c_ball_spd;
  assign w_hit_r = abs_diff(r_py, r_cur_r) < c_hit_win;
  assign w_hit_l = abs_diff(r_py, r_cur_l) < c_hit_win;

  always_comb begin
    w_py_n   = r_py;
    w_dy_n   = r_dy;
    w_px_n   = r_px;
    w_dx_n   = r_dx;
    w_miss_r = 1'b0;
    w_miss_l = 1'b0;
    if (r_dy) begin
      if (r_py + c_ball_spd >= c_y_max) begin
        w_py_n = c_y_max;
        w_dy_n = 1'b0;
      end else begin
        w_py_n = r_py + c_ball_spd;
      end
    end else if (r_py <= c_y_min + c_ball_spd) begin
      w_py_n = c_y_min;
      w_dy_n = 1'b1;
    end else begin
      w_py_n = r_py - c_ball_spd;
    end
    // Face tests require the ball to start in front of the paddle, so a ball already past it is never re-hit.
    if (r_dx) begin
      if (r_px < c_r_face && w_nx >= c_r_face && w_hit_r) begin
        w_px_n = c_r_face;
        w_dx_n = 1'b0;
      end else if (w_nx >= c_r_miss) begin
        w_miss_r = 1'b1;
      end else begin
        w_px_n = w_nx;
      end
    end else begin
      if (r_px > c_l_face && r_px <= c_l_face + c_ball_spd && w_hit_l) begin
        w_px_n = c_l_face;
        w_dx_n = 1'b1;
      end else if (r_px <= c_l_miss) begin
        w_miss_l = 1'b1;
      end else begin
        w_px_n = r_px - c_ball_spd;
      end
    end
  end

  always_ff @(posedge pxClk) begin
    if (rst) begin
      r_prev    <= 1'b0;
      r_tick    <= 1'b0;
      r_state   <= ST_SERVE;
      r_cnt     <= '0;
      r_cur_l   <= c_center_y;
      r_cur_r   <= c_center_y;
      r_px      <= c_center_x;
      r_py      <= c_center_y;
      r_dx      <= 1'b1;
      r_dy      <= 1'b1;
      r_score_l <= '0;
      r_score_r <= '0;
    end else begin
      r_prev <= frame_tick;
      r_tick <= frame_tick & ~r_prev;
      if (r_tick) begin
        r_cur_l <= paddle_next(r_cur_l, left_up, left_down);
        r_cur_r <= paddle_next(r_cur_r, right_up, right_down);
      end
      if (start && r_state == ST_OVER) begin
        r_score_l <= '0;
        r_score_r <= '0;
        r_dx      <= 1'b1;
        r_dy      <= 1'b1;
        r_cnt     <= '0;
        r_state   <= ST_SERVE;
      end else if (r_tick) begin
        case (r_state)
          ST_SERVE: begin
            r_px <= c_center_x;
            r_py <= c_center_y;
            if (r_cnt == c_cnt_last) begin
              r_cnt   <= '0;
              r_state <= ST_PLAY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_PLAY: begin
            if (w_miss_r || w_miss_l) begin
              r_px  <= c_center_x;
              r_py  <= c_center_y;
              r_dy  <= 1'b1;
              r_dx  <= w_miss_r;
              r_cnt <= '0;
              if (w_miss_r) begin
                if (r_score_l < c_win) r_score_l <= r_score_l + 4'd1;
                r_state <= (r_score_l + 4'd1 >= c_win) ? ST_OVER : ST_SERVE;
              end else begin
                if (r_score_r < c_win) r_score_r <= r_score_r + 4'd1;
                r_state <= (r_score_r + 4'd1 >= c_win) ? ST_OVER : ST_SERVE;
              end
            end else begin
              r_px <= w_px_n;
              r_py <= w_py_n;
              r_dx <= w_dx_n;
              r_dy <= w_dy_n;
            end
          end
          ST_OVER: begin
            r_px <= c_center_x;
            r_py <= c_center_y;
          end
          default: r_state <= ST_SERVE;
        endcase
      end
    end
  end

  assign cursor_left_py  = r_cur_l;
  assign cursor_right_py = r_cur_r;
  assign ball_px         = r_px;
  assign ball_py         = r_py;
  assign score_left      = r_score_l;
  assign score_right     = r_score_r;
  assign game_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_physics.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_physics
// Description : Directed self-checking bench for pong_physics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_physics;

  logic        pxClk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        left_up = 1'b0, left_down = 1'b0, right_up = 1'b0, right_down = 1'b0;
  logic        start = 1'b0;
  logic [11:0] cursor_left_py, cursor_right_py, ball_px, ball_py;
  logic [3:0]  score_left, score_right;
  logic [1:0]  game_state;

  int total = 0;
  int bad = 0;

  pong_physics dut (
    .pxClk          (pxClk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .left_up        (left_up),
    .left_down      (left_down),
    .right_up       (right_up),
    .right_down     (right_down),
    .start          (start),
    .cursor_left_py (cursor_left_py),
    .cursor_right_py(cursor_right_py),
    .ball_px        (ball_px),
    .ball_py        (ball_py),
    .score_left     (score_left),
    .score_right    (score_right),
    .game_state     (game_state)
  );

  always #5 pxClk = ~pxClk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Two cycles high, two low; the update has landed by the final negedge.
  task automatic tick();
    @(negedge pxClk) frame_tick = 1'b1;
    @(negedge pxClk);
    @(negedge pxClk) frame_tick = 1'b0;
    @(negedge pxClk);
    @(negedge pxClk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    repeat (3) @(negedge pxClk);
    rst = 1'b0;
    @(negedge pxClk);
    chk("rst_cur_l", cursor_left_py, 480);
    chk("rst_cur_r", cursor_right_py, 480);
    chk("rst_px", ball_px, 640);
    chk("rst_py", ball_py, 480);
    chk("rst_score_l", score_left, 0);
    chk("rst_score_r", score_right, 0);
    chk("rst_state", game_state, 0);

    ticks(59);
    chk("serve59_state", game_state, 0);
    tick();
    chk("serve60_state", game_state, 1);
    chk("serve60_px", ball_px, 640);
    chk("serve60_py", ball_py, 480);
    tick();
    chk("move1_px", ball_px, 644);
    chk("move1_py", ball_py, 484);

    left_up = 1'b1; right_down = 1'b1;
    ticks(100);
    left_up = 1'b0; right_down = 1'b0;
    chk("left_up_clamp", cursor_left_py, 80);
    chk("right_down_clamp", cursor_right_py, 880);
    chk("move101_px", ball_px, 1044);

    left_up = 1'b1; left_down = 1'b1;
    ticks(10);
    left_up = 1'b0; left_down = 1'b0;
    chk("both_btn_hold", cursor_left_py, 80);

    ticks(6);
    chk("wall_py", ball_py, 945);
    chk("wall_px", ball_px, 1108);
    tick();
    chk("wall_after_py", ball_py, 941);
    chk("wall_after_px", ball_px, 1112);

    ticks(29);
    chk("hit_px", ball_px, 1225);
    chk("hit_py", ball_py, 825);
    tick();
    chk("hit_after_px", ball_px, 1221);
    chk("hit_after_py", ball_py, 821);

    @(negedge pxClk) rst = 1'b1;
    @(negedge pxClk) rst = 1'b0;
    chk("midrst_cur_l", cursor_left_py, 480);
    chk("midrst_cur_r", cursor_right_py, 480);
    chk("midrst_px", ball_px, 640);
    chk("midrst_py", ball_py, 480);
    chk("midrst_state", game_state, 0);

    ticks(60 + 156);
    chk("premiss_px", ball_px, 1264);
    chk("premiss_py", ball_py, 789);
    chk("premiss_score", score_left, 0);
    @(negedge pxClk) start = 1'b1;
    @(negedge pxClk) start = 1'b0;
    chk("start_ignored_state", game_state, 1);
    chk("start_ignored_px", ball_px, 1264);
    tick();
    chk("miss_score_l", score_left, 1);
    chk("miss_score_r", score_right, 0);
    chk("miss_state", game_state, 0);
    chk("miss_px", ball_px, 640);
    chk("miss_py", ball_py, 480);

    for (int r = 0; r < 8; r++) begin
      ticks(60 + 157);
      chk("round_score", score_left, r + 2);
    end
    chk("over_state", game_state, 2);
    ticks(5);
    chk("over_hold_state", game_state, 2);
    chk("over_hold_px", ball_px, 640);
    chk("over_hold_py", ball_py, 480);
    chk("over_score_sat", score_left, 9);

    right_up = 1'b1;
    ticks(3);
    right_up = 1'b0;
    chk("over_paddle", cursor_right_py, 462);

    @(negedge pxClk) start = 1'b1;
    @(negedge pxClk) start = 1'b0;
    chk("start_score_l", score_left, 0);
    chk("start_state", game_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pong_physics.md
# pong_physics

Per-frame game-state engine for the pong SoC. It advances paddle and ball positions once per video frame from player button inputs and applies wall bounces, paddle hits, scoring and serve/game-over sequencing. It feeds the center-coordinate position buses (`cursor_left_py`, `cursor_right_py`, `ball_px`, `ball_py`) consumed by the pong drawer. It runs in the pixel clock domain.

## Interface
- CURSOR_WIDTH, 20, paddle width (px)
- CURSOR_OFFSET, 20, gap between the screen edge and the paddle (px)
- CURSOR_HEIGHT, 160, paddle height (px)
- BALL_SIDE, 30, ball side (px)
- FRAME_WIDTH, 1280, active width
- FRAME_HEIGHT, 960, active height
- BALL_SPEED, 4, ball step per frame on each axis
- CURSOR_SPEED, 6, paddle step per frame
- SERVE_FRAMES, 60, frames the ball is held at center before play
- WIN_SCORE, 9, score that ends the game
- pxClk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  frame strobe (e.g. Vsync-derived level); each rising edge is one tick
- left_up, left_down, right_up, right_down  in  1 each  paddle buttons, already synchronized
- start  in  1  leaves GAMEOVER
- cursor_left_py, cursor_right_py  out  12  paddle center Y
- ball_px, ball_py  out  12  ball center
- score_left, score_right  out  4  scores
- game_state  out  2  0=SERVE, 1=PLAY, 2=GAMEOVER

## Operation
- Tick: a registered copy of frame_tick is kept; tick = frame_tick & ~prev. All game state changes only on a tick cycle, except rst and start.
- Reset values:
  - cursors = 480; ball = (640, 480); dx = +1, dy = +1; scores = 0; state = SERVE; serve counter = 0.
- Paddles (in every state, on each tick):
  - up alone: py -= CURSOR_SPEED, clamped to min 80 (CURSOR_HEIGHT/2).
  - down alone: py += CURSOR_SPEED, clamped to max 880.
  - both buttons or neither: no change.
  - Clamp compares happen before the subtract, so there is never an underflow.
- SERVE:
  - Ball is held at center.
  - The counter increments on each tick. On the tick where counter == SERVE_FRAMES-1, the state goes to PLAY and the counter clears.
  - The ball does not move on that tick.
- PLAY, Y axis (per tick):
  - dy=+1: if py+BALL_SPEED >= 945, set py = 945 and dy = -1; else py += BALL_SPEED.
  - dy=-1: if py <= 19, set py = 15 and dy = +1; else py -= BALL_SPEED.
- PLAY, X axis, right side (dx=+1), with nx = px+BALL_SPEED:
  - Hit: px < 1225, nx >= 1225, and |ball_py − cursor_right_py| < 95 ((CURSOR_HEIGHT+BALL_SIDE)/2). Then px = 1225 and dx = -1.
  - Otherwise, if nx >= 1265: miss. score_left++.
  - Otherwise, px = nx.
- PLAY, X axis, left side (dx=-1), mirrored:
  - Hit: px > 55, px <= 55+BALL_SPEED, and |ball_py − cursor_left_py| < 95. Then px = 55 and dx = +1.
  - Otherwise, if px <= 19: miss. score_right++.
  - Otherwise, px -= BALL_SPEED.
- Collision inputs: the hit test uses the pre-tick ball_py and pre-tick cursor values. Paddles and ball update on the same tick.
- A ball already behind a paddle face is never re-hit.
- Miss handling:
  - Ball returns to center; dy = +1.
  - dx points toward the player who conceded (right miss → dx = +1).
  - Serve counter clears.
  - Next state is GAMEOVER if the incremented score == WIN_SCORE, else SERVE.
  - The Y update on a miss tick is discarded.
- GAMEOVER:
  - Ball is held at center; paddles still move.
  - start high in any cycle: scores = 0, dx = +1, dy = +1, counter = 0, state = SERVE on the next edge.
- Scores saturate at WIN_SCORE; no wrap.

## Timing
- All outputs are registered. A tick detected at edge N (frame_tick high, prev low) makes updated outputs visible after edge N+1.
- Throughput is one update per tick. Ticks fewer than 2 cycles apart are unsupported.
- rst takes priority over everything. Asserting it mid-rally restores all reset values at the next edge, and prev is cleared.
- start is ignored outside GAMEOVER. Reset has priority over start.

## Test plan
- Reset → outputs 480/480/(640,480), scores 0, state SERVE. After 60 ticks the state is PLAY with the ball still at (640,480). Tick 61 → ball (644,484).
- left_up held 100 ticks → cursor_left_py = 80. Then both left buttons held 10 ticks → cursor_left_py stays 80. right_down held 100 ticks → cursor_right_py = 880.
- Wall bounce: from serve, PLAY move 117 → ball_py = 945, dy = -1, ball_px = 1108.
- Right paddle hit: cursor_right_py parked at 880. Move 147 → ball (1225, 825), dx = -1.
- Right miss: cursor_right_py at 480. Move 157 → score_left = 1, state SERVE, ball (640,480), dx = +1.
- Game over: repeat the right-miss scenario 9 times → score_left = 9, state GAMEOVER, ball fixed at center. start pulse → scores 0 and state SERVE on the next edge. rst mid-rally → reset values after one edge.
